// File: rtl/shift_fifo.sv
// Shift-register FIFO: stage 0 is the head and drives data_out directly.
// Occupancy flags and the overflow/underflow pulses are all registered.
module shift_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [WIDTH-1:0]           fill_in,
  input  logic                       shift_in,
  input  logic                       shift_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_reg, data_next;
  logic [DEPTH-1:0]            filled_reg, filled_next;
  logic [CW-1:0]               count_reg, count_next, wr_idx;
  logic                        full_reg, empty_reg, af_reg, ae_reg;
  logic                        overflow_reg, underflow_reg;
  logic                        pop_acc, push_acc;

  assign pop_acc    = shift_out && (count_reg != '0);
  assign push_acc   = shift_in && ((count_reg != CW'(DEPTH)) || pop_acc);
  // Push lands in the lowest empty stage as seen after this cycle's shift.
  assign wr_idx     = count_reg - CW'(pop_acc);
  assign count_next = count_reg + CW'(push_acc) - CW'(pop_acc);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] shifted_d;
      logic             shifted_f;
      logic             wr_here;
      if (gi < DEPTH - 1) begin : g_mid
        // Empty stages keep their old data so the head holds its last word.
        assign shifted_d = (pop_acc && filled_reg[gi+1]) ? data_reg[gi+1] : data_reg[gi];
        assign shifted_f = pop_acc ? filled_reg[gi+1] : filled_reg[gi];
      end else begin : g_last
        assign shifted_d = data_reg[gi];
        assign shifted_f = filled_reg[gi] & ~pop_acc;
      end
      assign wr_here          = push_acc && (wr_idx == CW'(gi));
      assign data_next[gi]    = wr_here ? fill_in : shifted_d;
      assign filled_next[gi]  = wr_here | shifted_f;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      data_reg      <= '0;
      filled_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      af_reg        <= (AF_LEVEL == 0);
      ae_reg        <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      data_reg      <= data_next;
      filled_reg    <= filled_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == CW'(DEPTH));
      empty_reg     <= (count_next == '0);
      af_reg        <= (int'(count_next) >= AF_LEVEL);
      ae_reg        <= (int'(count_next) <= AE_LEVEL);
      overflow_reg  <= shift_in && !push_acc;
      underflow_reg <= shift_out && (count_reg == '0);
    end
  end

  assign data_out     = data_reg[0];
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_shift_fifo.sv
// Scoreboarded bench for shift_fifo (WIDTH=8, DEPTH=4, AF=3, AE=1) with a queue model.
module tb_shift_fifo;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] fill_in = 8'h00;
  logic       shift_in = 1'b0;
  logic       shift_out = 1'b0;
  logic [7:0] data_out;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  shift_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .res(res), .fill_in(fill_in), .shift_in(shift_in), .shift_out(shift_out),
    .data_out(data_out), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] cnt;
    logic       full, empty, af, ae, ov, un;
    logic [7:0] head;
    logic       chk_head;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of stimulus and record what the FIFO must show after that edge.
  task automatic step(input logic r, input logic p, input logic q, input logic [7:0] d);
    exp_t e;
    int   n;
    bit   pa, pu;
    @(negedge clk);
    res = r; shift_in = p; shift_out = q; fill_in = d;
    e = '0;
    if (r) begin
      mq.delete();
    end else begin
      n  = mq.size();
      pa = q && (n > 0);
      pu = p && ((n < 4) || pa);
      e.ov = p && !pu;
      e.un = q && (n == 0);
      if (pa) void'(mq.pop_front());
      if (pu) mq.push_back(d);
    end
    e.cnt   = 3'(mq.size());
    e.full  = (mq.size() == 4);
    e.empty = (mq.size() == 0);
    e.af    = (mq.size() >= 3);
    e.ae    = (mq.size() <= 1);
    e.chk_head = r || (mq.size() > 0);
    e.head  = (mq.size() > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every registered output shortly after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("count", {5'd0, count}, {5'd0, e.cnt});
        chk("full", {7'd0, full}, {7'd0, e.full});
        chk("empty", {7'd0, empty}, {7'd0, e.empty});
        chk("almost_full", {7'd0, almost_full}, {7'd0, e.af});
        chk("almost_empty", {7'd0, almost_empty}, {7'd0, e.ae});
        chk("overflow", {7'd0, overflow}, {7'd0, e.ov});
        chk("underflow", {7'd0, underflow}, {7'd0, e.un});
        if (e.chk_head) chk("data_out", data_out, e.head);
        if ($isunknown(data_out)) begin
          miscompares++;
          $display("FAIL data_out_x at %0t: got %b, expected known value", $time, data_out);
        end
      end
    end
  end

  initial begin
    int pp, qp;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    // Fill then drain in order.
    step(0, 1, 0, 8'h11); step(0, 1, 0, 8'h22); step(0, 1, 0, 8'h33); step(0, 1, 0, 8'h44);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    // Overflow alone, then push with pop while full.
    step(0, 1, 0, 8'h11); step(0, 1, 0, 8'h22); step(0, 1, 0, 8'h33); step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h55);
    step(0, 0, 0, 8'h00);
    step(0, 1, 1, 8'h55);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);
    // Underflow, and push with pop on empty.
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 1, 1, 8'hAA);
    step(0, 0, 1, 8'h00);
    // Push with pop at count 2.
    step(0, 1, 0, 8'h01); step(0, 1, 0, 8'h02);
    step(0, 1, 1, 8'h03);
    step(0, 0, 1, 8'h00); step(0, 0, 1, 8'h00);
    // Reset beats a concurrent push; first push after reset is accepted.
    step(0, 1, 0, 8'hA1); step(0, 1, 0, 8'hA2); step(0, 1, 0, 8'hA3);
    step(1, 1, 0, 8'h99);
    step(0, 1, 0, 8'h7E);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    // Random traffic with phases biased toward full and toward empty.
    pp = 50; qp = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 200 == 0) begin
        pp = $urandom_range(10, 90);
        qp = $urandom_range(10, 90);
      end
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < pp),
           ($urandom_range(0, 99) < qp), 8'($urandom));
    end
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
